// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: streams W-bit operands LSB-first through an
// external 1-bit full adder and returns the assembled sum and carry-out.
module serial_add_seq #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_cin,
    input  logic         fa_s,
    input  logic         fa_cout
);

    localparam int unsigned CW  = (W > 1) ? $clog2(W) : 1;
    // Index of the bit that reaches position 0 after the next shift.
    localparam int unsigned NXT = (W > 1) ? 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT         state;
    logic [W-1:0]  aSh;
    logic [W-1:0]  bSh;
    logic [W-1:0]  sumSh;
    logic          carry;
    logic [CW-1:0] cnt;

    logic lastBit;
    assign lastBit = (cnt == CW'(W - 1));

    assign sum  = sumSh;
    assign cout = carry;

    // Full-adder drives are registered one cycle ahead so they present the
    // bit pair for the RUN cycle that follows each edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            aSh       <= '0;
            bSh       <= '0;
            sumSh     <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            fa_a      <= 1'b0;
            fa_b      <= 1'b0;
            fa_cin    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        aSh      <= a;
                        bSh      <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        fa_a     <= a[0];
                        fa_b     <= b[0];
                        fa_cin   <= cin;
                    end
                end
                RUN: begin
                    aSh   <= aSh >> 1;
                    bSh   <= bSh >> 1;
                    sumSh <= W'({fa_s, sumSh} >> 1);
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (lastBit) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        fa_a      <= 1'b0;
                        fa_b      <= 1'b0;
                        fa_cin    <= 1'b0;
                    end else begin
                        fa_a   <= aSh[NXT];
                        fa_b   <= bSh[NXT];
                        fa_cin <= fa_cout;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    fa_a      <= 1'b0;
                    fa_b      <= 1'b0;
                    fa_cin    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq at W=8 and W=1 against a+b+cin.
module tb_serial_add_seq;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy, cin, cout;
    logic [W-1:0] a, b, sum;
    logic         fa_a, fa_b, fa_cin, fa_s, fa_cout;

    logic in_valid1, in_ready1, out_valid1, out_ready1, busy1, cin1, cout1;
    logic a1, b1, sum1;
    logic fa_a1, fa_b1, fa_cin1, fa_s1, fa_cout1;

    // External full-adder cells
    assign fa_s     = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    assign fa_s1    = fa_a1 ^ fa_b1 ^ fa_cin1;
    assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

    serial_add_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy), .fa_a(fa_a), .fa_b(fa_b),
        .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout)
    );

    serial_add_seq #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1), .fa_a(fa_a1), .fa_b(fa_b1),
        .fa_cin(fa_cin1), .fa_s(fa_s1), .fa_cout(fa_cout1)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [W:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Issue one operation from IDLE, collect the result, and accept it immediately.
    task automatic runOp(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                         output logic [W-1:0] rs, output logic rc, output int lat,
                         output logic [W-1:0] faTr);
        @(negedge clk);
        a = ta; b = tb2; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 1; faTr = '0;
        while (!out_valid && lat < 4 * W + 8) begin
            if (lat <= W) faTr[lat-1] = fa_a;
            @(negedge clk);
            lat++;
        end
        rs = sum; rc = cout;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({in_ready, out_valid, busy, sum, cout, fa_a, fa_b, fa_cin} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 4'b0}) begin
            errors++;
            $display("FAIL reset_w8: got rdy=%b ov=%b busy=%b sum=%h cout=%b fa=%b%b%b expected 1 0 0 00 0 000",
                     in_ready, out_valid, busy, sum, cout, fa_a, fa_b, fa_cin);
        end
        checks++;
        if ({in_ready1, out_valid1, busy1, sum1, cout1, fa_a1, fa_b1, fa_cin1} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_w1: got %b expected 10000000",
                     {in_ready1, out_valid1, busy1, sum1, cout1, fa_a1, fa_b1, fa_cin1});
        end
    endtask

    task automatic test_basic;
        logic [W-1:0] s, tr; logic c; int lat;
        runOp(8'h0F, 8'h01, 1'b0, s, c, lat, tr);
        checks++;
        if (lat !== W + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, W + 1); end
        checks++;
        if ({c, s} !== refAdd(8'h0F, 8'h01, 1'b0)) begin
            errors++; $display("FAIL basic_sum: got %b_%h expected %h", c, s, refAdd(8'h0F, 8'h01, 1'b0));
        end
        checks++;
        if (tr !== 8'b0000_1111) begin errors++; $display("FAIL basic_fa_a_trace: got %b expected 00001111", tr); end
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++; $display("FAIL basic_idle_after: got %b expected 100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_carry;
        logic [W-1:0] s, tr; logic c; int lat;
        runOp(8'hFF, 8'h01, 1'b0, s, c, lat, tr);
        checks++;
        if ({c, s} !== 9'h100) begin errors++; $display("FAIL carry_ff_01: got %b_%h expected 1_00", c, s); end
        runOp(8'hFF, 8'h00, 1'b1, s, c, lat, tr);
        checks++;
        if ({c, s} !== 9'h100) begin errors++; $display("FAIL carry_ff_cin: got %b_%h expected 1_00", c, s); end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] s; logic c; int n;
        @(negedge clk);
        a = 8'hA5; b = 8'h5A; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (!out_valid) begin errors++; $display("FAIL bp_timeout: out_valid=%b expected 1", out_valid); end
        s = sum; c = cout;
        checks++;
        if ({c, s} !== refAdd(8'hA5, 8'h5A, 1'b1)) begin
            errors++; $display("FAIL bp_sum: got %b_%h expected 1_00", c, s);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
            @(negedge clk);
            checks++;
            if ({sum, cout, in_ready, out_valid, busy} !== {s, c, 3'b011}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got sum=%h cout=%b rdy=%b ov=%b busy=%b expected %h %b 0 1 1",
                         i, sum, cout, in_ready, out_valid, busy, s, c);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++; $display("FAIL bp_release: got %b expected 100", {in_ready, out_valid, busy});
        end
        @(negedge clk);
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL bp_no_overlap: got rdy=%b busy=%b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [W-1:0] s, tr; logic c; int lat;
        @(negedge clk);
        a = 8'h55; b = 8'h33; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, sum, cout, fa_a, fa_b, fa_cin} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 4'b0}) begin
            errors++;
            $display("FAIL midrun_reset: got rdy=%b ov=%b busy=%b sum=%h cout=%b fa=%b%b%b expected 1 0 0 00 0 000",
                     in_ready, out_valid, busy, sum, cout, fa_a, fa_b, fa_cin);
        end
        rst_n = 1'b1;
        runOp(8'h03, 8'h05, 1'b0, s, c, lat, tr);
        checks++;
        if ({c, s} !== 9'h008) begin errors++; $display("FAIL midrun_after: got %b_%h expected 0_08", c, s); end
    endtask

    task automatic test_w1;
        int lat;
        for (int v = 7; v >= 0; v--) begin
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; in_valid1 = 1'b1; out_ready1 = 1'b0;
            @(negedge clk);
            in_valid1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            lat = 1;
            while (!out_valid1 && lat < 20) begin @(negedge clk); lat++; end
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL w1_latency_%0d: got %0d expected 2", v, lat); end
            checks++;
            if ({cout1, sum1} !== 2'(v[2] + v[1] + v[0])) begin
                errors++; $display("FAIL w1_sum_%0d: got %b%b expected %0d", v, cout1, sum1, v[2] + v[1] + v[0]);
            end
            out_ready1 = 1'b1;
            @(negedge clk);
            out_ready1 = 1'b0;
        end
    endtask

    task automatic test_interval;
        int acc[$];
        int cyc = 0;
        out_ready = 1'b1; in_valid = 1'b1;
        while (acc.size() < 5 && cyc < 200) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (in_ready) acc.push_back(cyc);
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (acc.size() != 5) begin errors++; $display("FAIL interval_timeout: got %0d accepts expected 5", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != W + 2) begin
                errors++; $display("FAIL interval_%0d: got %0d expected %0d", i, acc[i] - acc[i-1], W + 2);
            end
        end
        while (busy && cyc < 400) begin @(negedge clk); cyc++; end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [W:0] exp[$];
        logic [W:0] e;
        int sent = 0, got = 0, cyc = 0;
        logic prevOv = 1'b0, prevXfer = 1'b0;
        while (got < 1000 && cyc < 60000) begin
            @(negedge clk);
            checks++;
            if (prevOv && !prevXfer && !out_valid) begin
                errors++; $display("FAIL stream_ov_drop: out_valid fell without transfer at cycle %0d", cyc);
            end
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (exp.size() == 0) begin
                    errors++; $display("FAIL stream_spurious: result %b_%h with nothing outstanding", cout, sum);
                end else begin
                    e = exp.pop_front();
                    if ({cout, sum} !== e) begin
                        errors++; $display("FAIL stream_op_%0d: got %b_%h expected %h", got, cout, sum, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp.push_back(refAdd(a, b, cin));
                sent++;
            end
            prevOv = out_valid; prevXfer = out_valid && out_ready;
            cyc++;
        end
        checks++;
        if (got != 1000) begin errors++; $display("FAIL stream_count: got %0d results expected 1000", got); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_run();
        test_w1();
        test_interval();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial addition sequencer that time-shares a single 1-bit full-adder cell over W-bit operands. It accepts an operand pair and carry-in over a valid/ready handshake and feeds one bit pair per cycle, LSB first, to an external combinational full adder. It keeps the carry in a register between bits, assembles the sum, and returns sum and carry-out over a second valid/ready handshake. It sits between the operand source and the shared full-adder datapath and is the only driver of that cell's inputs.

## Interface
- W, 8: operand/sum width in bits; legal range W >= 1.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands this cycle.
- a  input  W  addend.
- b  input  W  addend.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  result held on sum/cout.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result bits [W-1:0].
- cout  output  1  carry out of bit W-1.
- busy  output  1  high while in RUN or DONE.
- fa_a  output  1  full-adder input a.
- fa_b  output  1  full-adder input b.
- fa_cin  output  1  full-adder carry input.
- fa_s  input  1  full-adder sum; combinational from fa_* in the same cycle.
- fa_cout  input  1  full-adder carry out; combinational, same cycle.

## Operation
- Three states: IDLE, RUN, DONE.
- Registers:
  - a_sh and b_sh, W bits each.
  - sum_sh, W bits.
  - carry, 1 bit.
  - bit counter cnt, width max(1, clog2(W)).
- **IDLE:**
  - in_ready=1, out_valid=0, busy=0.
  - On in_valid: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to RUN.
- **RUN:**
  - in_ready=0, busy=1.
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry.
  - Each edge: a_sh and b_sh shift right by 1; sum_sh<={fa_s, sum_sh[W-1:1]}; carry<=fa_cout; cnt<=cnt+1.
  - When cnt==W-1 at the edge, go to DONE. The final shift is completed on that edge.
- **DONE:**
  - out_valid=1, busy=1.
  - sum=sum_sh, cout=carry, held stable until accepted.
  - On out_ready, go to IDLE.
- fa_a, fa_b and fa_cin are driven 0 in IDLE and DONE. fa_s and fa_cout are ignored outside RUN.
- sum and cout outputs:
  - Reflect sum_sh and carry registers at all times.
  - Are meaningful only while out_valid=1.
- Arithmetic is modulo 2^W. cout is the true bit W of a+b+cin.
- W=1: RUN lasts exactly one cycle. The cnt compare is against 0.
- Inputs a, b and cin are sampled only on the accepting edge. Later changes do not affect the result in flight.
- No overlap: a new operand is never accepted in RUN or DONE, including a DONE cycle with out_ready=1.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - a_sh, b_sh, sum_sh, carry, cnt all 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, fa_*=0.
  - Reset overrides every transition, including mid-RUN and a DONE cycle with out_ready=1. The in-flight operation is discarded with no output.
- Accept edge = E (in_valid & in_ready).
- RUN occupies cycles E+1 through E+W.
- out_valid first high in cycle E+W+1.
- Latency from accept to out_valid: W+1 cycles.
- Result transfer occurs on an edge with out_valid & out_ready; in_ready returns high the next cycle.
- Minimum initiation interval: W+2 cycles with out_ready held high.
- in_valid is not required to be held. Deasserting in_valid without acceptance is legal; the block takes no action.
- out_valid never drops without a transfer except on reset.

## Test plan
- W=8: a=0x0F, b=0x01, cin=0 -> out_valid 9 cycles after accept, sum=0x10, cout=0. fa_a over RUN cycles = 1,1,1,1,0,0,0,0.
- W=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Carry ripples through all 8 RUN cycles.
- Backpressure: W=8, a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Hold out_ready=0 for 5 cycles: sum/cout stable, in_ready=0, a second in_valid is ignored. Raise out_ready: IDLE the next cycle.
- Reset mid-RUN: assert rst_n=0 at cnt=3. Next cycle all outputs are at reset values; a fresh 0x03+0x05, cin=0 then yields sum=0x08, cout=0.
- W=1: {a,b,cin}=1,1,1 -> sum=1, cout=1, out_valid 2 cycles after accept. Randomised back-to-back stream of 1000 ops at W=8 matches a+b+cin.
